sub_bytes_engine: RTL and testbench

Iterative forward AES SubBytes unit for the encryption datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes every byte through forward S-box lanes, LANES bytes per cycle. It then presents the substituted state over a second valid/ready handshake. It is the encrypt-side counterpart of the inverse S-box used in decryption, and sits between AddRoundKey and ShiftRows in the round controller.

---
 rtl/sub_bytes_engine_pkg.sv | 14 +
 rtl/sbox.sv | 43 ++++
 rtl/sub_bytes_engine.sv | 94 +++++++++
 tb/tb_sub_bytes_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES types and constants for the SubBytes engine.
package sub_bytes_engine_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [7:0]             aes_byte_t;
  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sbe_state_e;
endpackage

// File: rtl/sbox.sv
// Combinational FIPS-197 forward S-box; same interface as the inverse S-box.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  always_comb begin
    c = 8'h00;
    case (a)
      8'h00: c = 8'h63; 8'h01: c = 8'h7c; 8'h02: c = 8'h77; 8'h03: c = 8'h7b; 8'h04: c = 8'hf2; 8'h05: c = 8'h6b; 8'h06: c = 8'h6f; 8'h07: c = 8'hc5;
      8'h08: c = 8'h30; 8'h09: c = 8'h01; 8'h0a: c = 8'h67; 8'h0b: c = 8'h2b; 8'h0c: c = 8'hfe; 8'h0d: c = 8'hd7; 8'h0e: c = 8'hab; 8'h0f: c = 8'h76;
      8'h10: c = 8'hca; 8'h11: c = 8'h82; 8'h12: c = 8'hc9; 8'h13: c = 8'h7d; 8'h14: c = 8'hfa; 8'h15: c = 8'h59; 8'h16: c = 8'h47; 8'h17: c = 8'hf0;
      8'h18: c = 8'had; 8'h19: c = 8'hd4; 8'h1a: c = 8'ha2; 8'h1b: c = 8'haf; 8'h1c: c = 8'h9c; 8'h1d: c = 8'ha4; 8'h1e: c = 8'h72; 8'h1f: c = 8'hc0;
      8'h20: c = 8'hb7; 8'h21: c = 8'hfd; 8'h22: c = 8'h93; 8'h23: c = 8'h26; 8'h24: c = 8'h36; 8'h25: c = 8'h3f; 8'h26: c = 8'hf7; 8'h27: c = 8'hcc;
      8'h28: c = 8'h34; 8'h29: c = 8'ha5; 8'h2a: c = 8'he5; 8'h2b: c = 8'hf1; 8'h2c: c = 8'h71; 8'h2d: c = 8'hd8; 8'h2e: c = 8'h31; 8'h2f: c = 8'h15;
      8'h30: c = 8'h04; 8'h31: c = 8'hc7; 8'h32: c = 8'h23; 8'h33: c = 8'hc3; 8'h34: c = 8'h18; 8'h35: c = 8'h96; 8'h36: c = 8'h05; 8'h37: c = 8'h9a;
      8'h38: c = 8'h07; 8'h39: c = 8'h12; 8'h3a: c = 8'h80; 8'h3b: c = 8'he2; 8'h3c: c = 8'heb; 8'h3d: c = 8'h27; 8'h3e: c = 8'hb2; 8'h3f: c = 8'h75;
      8'h40: c = 8'h09; 8'h41: c = 8'h83; 8'h42: c = 8'h2c; 8'h43: c = 8'h1a; 8'h44: c = 8'h1b; 8'h45: c = 8'h6e; 8'h46: c = 8'h5a; 8'h47: c = 8'ha0;
      8'h48: c = 8'h52; 8'h49: c = 8'h3b; 8'h4a: c = 8'hd6; 8'h4b: c = 8'hb3; 8'h4c: c = 8'h29; 8'h4d: c = 8'he3; 8'h4e: c = 8'h2f; 8'h4f: c = 8'h84;
      8'h50: c = 8'h53; 8'h51: c = 8'hd1; 8'h52: c = 8'h00; 8'h53: c = 8'hed; 8'h54: c = 8'h20; 8'h55: c = 8'hfc; 8'h56: c = 8'hb1; 8'h57: c = 8'h5b;
      8'h58: c = 8'h6a; 8'h59: c = 8'hcb; 8'h5a: c = 8'hbe; 8'h5b: c = 8'h39; 8'h5c: c = 8'h4a; 8'h5d: c = 8'h4c; 8'h5e: c = 8'h58; 8'h5f: c = 8'hcf;
      8'h60: c = 8'hd0; 8'h61: c = 8'hef; 8'h62: c = 8'haa; 8'h63: c = 8'hfb; 8'h64: c = 8'h43; 8'h65: c = 8'h4d; 8'h66: c = 8'h33; 8'h67: c = 8'h85;
      8'h68: c = 8'h45; 8'h69: c = 8'hf9; 8'h6a: c = 8'h02; 8'h6b: c = 8'h7f; 8'h6c: c = 8'h50; 8'h6d: c = 8'h3c; 8'h6e: c = 8'h9f; 8'h6f: c = 8'ha8;
      8'h70: c = 8'h51; 8'h71: c = 8'ha3; 8'h72: c = 8'h40; 8'h73: c = 8'h8f; 8'h74: c = 8'h92; 8'h75: c = 8'h9d; 8'h76: c = 8'h38; 8'h77: c = 8'hf5;
      8'h78: c = 8'hbc; 8'h79: c = 8'hb6; 8'h7a: c = 8'hda; 8'h7b: c = 8'h21; 8'h7c: c = 8'h10; 8'h7d: c = 8'hff; 8'h7e: c = 8'hf3; 8'h7f: c = 8'hd2;
      8'h80: c = 8'hcd; 8'h81: c = 8'h0c; 8'h82: c = 8'h13; 8'h83: c = 8'hec; 8'h84: c = 8'h5f; 8'h85: c = 8'h97; 8'h86: c = 8'h44; 8'h87: c = 8'h17;
      8'h88: c = 8'hc4; 8'h89: c = 8'ha7; 8'h8a: c = 8'h7e; 8'h8b: c = 8'h3d; 8'h8c: c = 8'h64; 8'h8d: c = 8'h5d; 8'h8e: c = 8'h19; 8'h8f: c = 8'h73;
      8'h90: c = 8'h60; 8'h91: c = 8'h81; 8'h92: c = 8'h4f; 8'h93: c = 8'hdc; 8'h94: c = 8'h22; 8'h95: c = 8'h2a; 8'h96: c = 8'h90; 8'h97: c = 8'h88;
      8'h98: c = 8'h46; 8'h99: c = 8'hee; 8'h9a: c = 8'hb8; 8'h9b: c = 8'h14; 8'h9c: c = 8'hde; 8'h9d: c = 8'h5e; 8'h9e: c = 8'h0b; 8'h9f: c = 8'hdb;
      8'ha0: c = 8'he0; 8'ha1: c = 8'h32; 8'ha2: c = 8'h3a; 8'ha3: c = 8'h0a; 8'ha4: c = 8'h49; 8'ha5: c = 8'h06; 8'ha6: c = 8'h24; 8'ha7: c = 8'h5c;
      8'ha8: c = 8'hc2; 8'ha9: c = 8'hd3; 8'haa: c = 8'hac; 8'hab: c = 8'h62; 8'hac: c = 8'h91; 8'had: c = 8'h95; 8'hae: c = 8'he4; 8'haf: c = 8'h79;
      8'hb0: c = 8'he7; 8'hb1: c = 8'hc8; 8'hb2: c = 8'h37; 8'hb3: c = 8'h6d; 8'hb4: c = 8'h8d; 8'hb5: c = 8'hd5; 8'hb6: c = 8'h4e; 8'hb7: c = 8'ha9;
      8'hb8: c = 8'h6c; 8'hb9: c = 8'h56; 8'hba: c = 8'hf4; 8'hbb: c = 8'hea; 8'hbc: c = 8'h65; 8'hbd: c = 8'h7a; 8'hbe: c = 8'hae; 8'hbf: c = 8'h08;
      8'hc0: c = 8'hba; 8'hc1: c = 8'h78; 8'hc2: c = 8'h25; 8'hc3: c = 8'h2e; 8'hc4: c = 8'h1c; 8'hc5: c = 8'ha6; 8'hc6: c = 8'hb4; 8'hc7: c = 8'hc6;
      8'hc8: c = 8'he8; 8'hc9: c = 8'hdd; 8'hca: c = 8'h74; 8'hcb: c = 8'h1f; 8'hcc: c = 8'h4b; 8'hcd: c = 8'hbd; 8'hce: c = 8'h8b; 8'hcf: c = 8'h8a;
      8'hd0: c = 8'h70; 8'hd1: c = 8'h3e; 8'hd2: c = 8'hb5; 8'hd3: c = 8'h66; 8'hd4: c = 8'h48; 8'hd5: c = 8'h03; 8'hd6: c = 8'hf6; 8'hd7: c = 8'h0e;
      8'hd8: c = 8'h61; 8'hd9: c = 8'h35; 8'hda: c = 8'h57; 8'hdb: c = 8'hb9; 8'hdc: c = 8'h86; 8'hdd: c = 8'hc1; 8'hde: c = 8'h1d; 8'hdf: c = 8'h9e;
      8'he0: c = 8'he1; 8'he1: c = 8'hf8; 8'he2: c = 8'h98; 8'he3: c = 8'h11; 8'he4: c = 8'h69; 8'he5: c = 8'hd9; 8'he6: c = 8'h8e; 8'he7: c = 8'h94;
      8'he8: c = 8'h9b; 8'he9: c = 8'h1e; 8'hea: c = 8'h87; 8'heb: c = 8'he9; 8'hec: c = 8'hce; 8'hed: c = 8'h55; 8'hee: c = 8'h28; 8'hef: c = 8'hdf;
      8'hf0: c = 8'h8c; 8'hf1: c = 8'ha1; 8'hf2: c = 8'h89; 8'hf3: c = 8'h0d; 8'hf4: c = 8'hbf; 8'hf5: c = 8'he6; 8'hf6: c = 8'h42; 8'hf7: c = 8'h68;
      8'hf8: c = 8'h41; 8'hf9: c = 8'h99; 8'hfa: c = 8'h2d; 8'hfb: c = 8'h0f; 8'hfc: c = 8'hb0; 8'hfd: c = 8'h54; 8'hfe: c = 8'hbb; 8'hff: c = 8'h16;
    endcase
  end
endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative forward SubBytes: substitutes LANES bytes of the held state per cycle,
// then presents the result until the downstream handshake.
module sub_bytes_engine
  import sub_bytes_engine_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int GROUPS = AES_BYTES / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sbe_state_e       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  aes_state_t       state_q, state_d;

  logic [6:0] lane_lo  [LANES];
  aes_byte_t  lane_out [LANES];

  // Each lane works on byte cnt*LANES+gi of the register in place.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_lo[gi] = 7'((int'(cnt_q) * LANES + gi) * 8);
    sbox u_sbox (
      .a (state_q[lane_lo[gi] +: 8]),
      .c (lane_out[gi])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_state;
          cnt_d   = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          state_d[lane_lo[l] +: 8] = lane_out[l];
        end
        if (cnt_q == CNT_W'(GROUPS - 1)) begin
          cnt_d = '0;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle capture in IDLE.
    if (clear) begin
      fsm_d   = IDLE;
      cnt_d   = '0;
      state_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign out_state = state_q;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Randomized self-checking bench for sub_bytes_engine across LANES = 4, 1, 2, 16,
// checked against a GF(2^8) inverse + affine reference S-box.
module tb_sub_bytes_engine;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic [1:0]   sel;

  logic         in_ready_w  [4];
  logic         out_valid_w [4];
  logic         busy_w      [4];
  logic [127:0] out_state_w [4];

  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] out_state_m;

  int checks = 0;
  int passes = 0;

  logic [7:0] sbox_ref [256];
  logic [7:0] inv_ref  [256];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sub_bytes_engine #(
      .LANES(gi == 0 ? 4 : gi == 1 ? 1 : gi == 2 ? 2 : 16)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid && (sel == 2'(gi))),
      .in_ready  (in_ready_w[gi]),
      .in_state  (in_state),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready && (sel == 2'(gi))),
      .out_state (out_state_w[gi]),
      .busy      (busy_w[gi])
    );
  end

  assign in_ready_m  = in_ready_w[sel];
  assign out_valid_m = out_valid_w[sel];
  assign busy_m      = busy_w[sel];
  assign out_state_m = out_state_w[sel];

  function automatic int lanes_of(input logic [1:0] idx);
    case (idx)
      2'd0: return 4;
      2'd1: return 1;
      2'd2: return 2;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (v != 0 && gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_ref[v] = s;
      inv_ref[s]  = 8'(v);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one state through engine idx; reports result, latency in edges after
  // acceptance (-1 on timeout), whether in_ready/busy misbehaved during the run,
  // and whether out_state/out_valid held during 'hold' cycles of backpressure.
  task automatic do_txn(input logic [1:0] idx, input logic [127:0] din,
                        input bit keep_valid, input logic [127:0] next_din,
                        input int hold, input bit early_ready,
                        output logic [127:0] dout, output int lat,
                        output bit leak, output bit bp_ok);
    int w;
    sel = idx; leak = 1'b0; bp_ok = 1'b1; lat = -1; dout = '0; w = 0;
    while (!in_ready_m && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready_m) return;
    in_valid = 1'b1; in_state = din;
    @(posedge clk); #1;
    if (keep_valid) in_state = next_din;
    else in_valid = 1'b0;
    out_ready = early_ready;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk); #1;
      if (in_ready_m || !busy_m) leak = 1'b1;
      if (out_valid_m) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      out_ready = 1'b0;
      return;
    end
    dout = out_state_m;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!out_valid_m || out_state_m !== dout || in_ready_m) bp_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn lanes=%0d in=%h out=%h lat=%0d", lanes_of(idx), din, dout, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; sel = 2'd0;
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || out_state_w[i] !== 128'h0)
        $display("FAIL reset inst=%0d: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
                 i, in_ready_w[i], out_valid_w[i], busy_w[i], out_state_w[i]);
      else passes++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [127:0] d; int lat; bit leak, bp;
    do_txn(2'd0, 128'h0, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
    checks++;
    if (d !== {16{8'h63}}) $display("FAIL zero_out: got %h, required %h", d, {16{8'h63}});
    else passes++;
    checks++;
    if (lat !== 4) $display("FAIL zero_latency: got %0d, required 4", lat);
    else passes++;
    checks++;
    if (leak !== 1'b0) $display("FAIL zero_busy: busy/in_ready wrong during run, got leak=%b required 0", leak);
    else passes++;
    checks++;
    if (busy_m !== 1'b0 || in_ready_m !== 1'b1)
      $display("FAIL zero_release: busy=%b in_ready=%b, required 0 1", busy_m, in_ready_m);
    else passes++;
  endtask

  task automatic test_known_vectors();
    logic [127:0] d; int lat; bit leak, bp;
    logic [127:0] exp_seq;
    exp_seq = 128'h76abd7fe2b670130c56f6bf27b777c63;
    do_txn(2'd0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
    checks++;
    if (d !== exp_seq) $display("FAIL known_seq: got %h, required %h", d, exp_seq);
    else passes++;
    do_txn(2'd0, {8'hff, 112'h0, 8'h53}, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
    checks++;
    if (d[7:0] !== 8'hed || d[127:120] !== 8'h16 || d[119:8] !== {14{8'h63}})
      $display("FAIL known_53_ff: got %h, required %h", d, {8'h16, {14{8'h63}}, 8'hed});
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [127:0] din, d; int lat; bit leak, bp;
    din = rand_state();
    do_txn(2'd0, din, 1'b0, 128'h0, 10, 1'b0, d, lat, leak, bp);
    checks++;
    if (d !== ref_sub(din)) $display("FAIL bp_out: got %h, required %h", d, ref_sub(din));
    else passes++;
    checks++;
    if (bp !== 1'b1) $display("FAIL bp_hold: out held stable flag got %b, required 1", bp);
    else passes++;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready_m, out_valid_m);
    else passes++;
    // out_ready high throughout the run must not shorten it.
    din = rand_state();
    do_txn(2'd0, din, 1'b0, 128'h0, 0, 1'b1, d, lat, leak, bp);
    checks++;
    if (d !== ref_sub(din) || lat !== 4)
      $display("FAIL early_ready: got %h lat=%0d, required %h lat=4", d, lat, ref_sub(din));
    else passes++;
  endtask

  task automatic test_abort();
    logic [127:0] din, d; int lat; bit leak, bp;
    sel = 2'd0;
    // clear mid-run at cnt=2
    in_valid = 1'b1; in_state = rand_state();
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 || out_state_m !== 128'h0)
      $display("FAIL clear_run: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
               in_ready_m, out_valid_m, busy_m, out_state_m);
    else passes++;
    // clear beats a same-cycle capture
    clear = 1'b1; in_valid = 1'b1; in_state = rand_state();
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy_m !== 1'b0 || out_state_m !== 128'h0)
      $display("FAIL clear_vs_valid: busy=%b out_state=%h, required 0 0", busy_m, out_state_m);
    else passes++;
    din = rand_state();
    do_txn(2'd0, din, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
    checks++;
    if (d !== ref_sub(din) || lat !== 4)
      $display("FAIL after_clear: got %h lat=%0d, required %h lat=4", d, lat, ref_sub(din));
    else passes++;
    // asynchronous reset mid-run, observed before any clock edge
    in_valid = 1'b1; in_state = rand_state();
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 || out_state_m !== 128'h0)
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
               in_ready_m, out_valid_m, busy_m, out_state_m);
    else passes++;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    din = rand_state();
    do_txn(2'd0, din, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
    checks++;
    if (d !== ref_sub(din) || lat !== 4)
      $display("FAIL after_reset: got %h lat=%0d, required %h lat=4", d, lat, ref_sub(din));
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] cur, nxt, d; int lat; bit leak, bp;
    for (int ii = 1; ii < 4; ii++) begin
      cur = rand_state();
      for (int n = 0; n < 500; n++) begin
        nxt = rand_state();
        do_txn(2'(ii), cur, n < 499, nxt, 0, 1'b0, d, lat, leak, bp);
        checks++;
        if (d !== ref_sub(cur))
          $display("FAIL b2b_out lanes=%0d n=%0d: got %h, required %h", lanes_of(2'(ii)), n, d, ref_sub(cur));
        else passes++;
        checks++;
        if (lat !== 16 / lanes_of(2'(ii)))
          $display("FAIL b2b_latency lanes=%0d n=%0d: got %0d, required %0d", lanes_of(2'(ii)), n, lat, 16 / lanes_of(2'(ii)));
        else passes++;
        checks++;
        if (leak !== 1'b0)
          $display("FAIL b2b_accept_while_busy lanes=%0d n=%0d: leak=%b, required 0", lanes_of(2'(ii)), n, leak);
        else passes++;
        cur = nxt;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_table();
    logic [127:0] din, d; int lat; bit leak, bp;
    logic [7:0] b, o;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) din[8*k +: 8] = 8'(j * 16 + k);
      do_txn(2'd3, din, 1'b0, 128'h0, 0, 1'b0, d, lat, leak, bp);
      for (int k = 0; k < 16; k++) begin
        b = 8'(j * 16 + k);
        o = d[8*k +: 8];
        checks++;
        if (o !== sbox_ref[b]) $display("FAIL table_sbox b=%h: got %h, required %h", b, o, sbox_ref[b]);
        else passes++;
        checks++;
        if (inv_ref[o] !== b) $display("FAIL table_inverse b=%h: inv(out %h)=%h, required %h", b, o, inv_ref[o], b);
        else passes++;
      end
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_zero();
    test_known_vectors();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_table();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
